fetch_controller: RTL and testbench



---
 rtl/fetch_controller.sv | 94 +++++++++
 tb/tb_fetch_controller.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/fetch_controller.sv
// fetch_controller: instruction fetch FSM (IDLE/FETCH/HALTED) with stall, redirect and halt handling.
// Define FETCH_PERF_CNT_EN to enable the saturating delivered-instruction counter on o_fetch_count.
module fetch_controller #(
    parameter logic [23:0] RESET_VECTOR = 24'd0,
    parameter logic [3:0]  HALT_OPCODE  = 4'hF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [23:0] o_pc,
    input  logic [23:0] i_inst,
    input  logic        i_stall,
    input  logic        i_redirect,
    input  logic [23:0] i_redirect_pc,
    output logic [23:0] o_ir,
    output logic [23:0] o_irpc,
    output logic        o_ir_valid,
    output logic        o_halted,
    output logic [15:0] o_fetch_count
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HALTED} state_t;

    state_t      r_state, w_state_next;
    logic [23:0] r_pc, r_ir, r_irpc, w_pc_next, w_ir_next, w_irpc_next;
    logic        r_ir_valid, r_halted, w_ir_valid_next, w_is_halt;

    assign w_is_halt = i_inst[23:20] == HALT_OPCODE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_VECTOR;
            r_ir       <= '0;
            r_irpc     <= '0;
            r_ir_valid <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_irpc     <= w_irpc_next;
            r_ir_valid <= w_ir_valid_next;
            r_halted   <= w_state_next == S_HALTED;
        end
    end

    // Redirect wins over everything; halt is only seen on a capturing edge
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_irpc_next     = r_irpc;
        w_ir_valid_next = r_ir_valid;
        if (i_redirect) begin
            w_state_next    = S_FETCH;
            w_pc_next       = i_redirect_pc;
            w_ir_valid_next = 1'b0;
        end else if (r_state == S_IDLE) begin
            w_state_next    = S_FETCH;
            w_ir_valid_next = 1'b0;
        end else if (r_state == S_HALTED) begin
            w_ir_valid_next = 1'b0;
        end else if (!i_stall) begin
            w_ir_next       = i_inst;
            w_irpc_next     = r_pc;
            w_ir_valid_next = 1'b1;
            w_state_next    = w_is_halt ? S_HALTED : S_FETCH;
            w_pc_next       = w_is_halt ? r_pc : r_pc + 24'd1;
        end
    end

    assign o_pc       = r_pc;
    assign o_ir       = r_ir;
    assign o_irpc     = r_irpc;
    assign o_ir_valid = r_ir_valid;
    assign o_halted   = r_halted;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_count;
    logic        w_capture;

    assign w_capture = r_state == S_FETCH && !i_redirect && !i_stall;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_fetch_count <= '0;
        else if (w_capture && r_fetch_count != 16'hFFFF)
            r_fetch_count <= r_fetch_count + 16'd1;
    end

    assign o_fetch_count = r_fetch_count;
`else
    assign o_fetch_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: randomized fetch stimulus with a reference model feeding a scoreboard queue.
module tb_fetch_controller;
    localparam logic [23:0] RV = 24'hFFFFFE;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, redir = 1'b0;
    logic [23:0] rpc = '0, pc, inst, ir, irpc;
    logic        ir_valid, halted;
    logic [15:0] fcnt;

    int n_tests = 0, n_fail = 0;

    fetch_controller #(.RESET_VECTOR(RV), .HALT_OPCODE(4'hF)) dut (
        .i_clk(clk), .i_rst(rst), .o_pc(pc), .i_inst(inst), .i_stall(stall),
        .i_redirect(redir), .i_redirect_pc(rpc), .o_ir(ir), .o_irpc(irpc),
        .o_ir_valid(ir_valid), .o_halted(halted), .o_fetch_count(fcnt)
    );

    always #5 clk = ~clk;

    // Memory image: addresses with low six bits == 7 hold a HALT word
    function automatic logic [23:0] mem(input logic [23:0] a);
        return {(a[5:0] == 6'h07) ? 4'hF : {1'b0, a[2:0]}, a[19:0] ^ 20'h5A5A5};
    endfunction

    assign inst = mem(pc);

    // Reference model: mode 0 = waiting to start, 1 = running, 2 = halted
    int          m_mode = 0;
    logic [23:0] m_pc = RV;
    logic        m_valid = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [47:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
        logic [23:0] w;
        if (rst) begin
            m_mode = 0; m_pc = RV; m_valid = 1'b0; m_cnt = '0;
            exp_q.delete();
        end else if (redir) begin
            m_mode = 1; m_pc = rpc; m_valid = 1'b0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            m_valid = 1'b0;
        end else if (!stall) begin
            w = mem(m_pc);
            exp_q.push_back({m_pc, w});
            m_valid = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (w[23:20] == 4'hF) m_mode = 2;
            else m_pc = m_pc + 24'd1;
        end
    end

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic        prev_v = 1'b0;
    logic [23:0] prev_pc = '0;

    always @(negedge clk) begin
        logic [47:0] e;
        if (rst) begin
            check("rst_pc", pc, RV);
            check("rst_ir", ir, 24'h0);
            check("rst_irpc", irpc, 24'h0);
            check("rst_valid", {23'd0, ir_valid}, 24'h0);
            check("rst_halted", {23'd0, halted}, 24'h0);
            check("rst_fcnt", {8'd0, fcnt}, 24'h0);
            prev_v = 1'b0;
        end else begin
            check("pc", pc, m_pc);
            check("halted", {23'd0, halted}, {23'd0, m_mode == 2});
            check("ir_valid", {23'd0, ir_valid}, {23'd0, m_valid});
            check("fcnt", {8'd0, fcnt}, PERF ? {8'd0, m_cnt} : 24'h0);
            if (ir_valid && (!prev_v || irpc != prev_pc)) begin
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL unexpected_delivery: got irpc %h expected none", irpc);
                end else begin
                    e = exp_q.pop_front();
                    check("irpc", irpc, e[47:24]);
                    check("ir", ir, e[23:0]);
                end
            end
            prev_v = ir_valid;
            prev_pc = irpc;
        end
    end

    task automatic step(input logic s, input logic r, input logic [23:0] t);
        @(negedge clk);
        #1;
        stall = s; redir = r; rpc = t;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        repeat (12) step(1'b0, 1'b0, 24'h0);
        repeat (12) step(1'($urandom_range(0, 1)), 1'b0, 24'h0);
        step(1'b0, 1'b1, 24'h000020);
        repeat (10) step(1'b0, 1'b0, 24'h0);
        step(1'b0, 1'b1, 24'h000003);
        repeat (3) step(1'b0, 1'b0, 24'h0);
        repeat (3) step(1'b1, 1'b0, 24'h0);
        repeat (2) step(1'b0, 1'b0, 24'h0);
        step(1'b1, 1'b1, 24'h000100);
        repeat (4) step(1'b0, 1'b0, 24'h0);
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                step(1'b1, 1'b0, 24'h0);
                #1 rst = 1'b1;
                @(negedge clk);
                #2 rst = 1'b0;
            end
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 11) == 0),
                 $urandom_range(0, 1) ? 24'($urandom_range(0, 200)) : 24'hFFFFF0 + 24'($urandom_range(0, 15)));
        end
        step(1'b1, 1'b0, 24'h0);
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
